// File: rtl/key_cond_pkg.sv
// Shared types and default timing for the key conditioning front end.
// Defaults assume a 50 MHz system clock.
package key_cond_pkg;

    // Auto-repeat state of one key channel.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEATING = 2'd2
    } rep_state_t;

    localparam int DEF_NUM_KEYS        = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
    localparam int DEF_REPEAT_DELAY    = 25_000_000;  // 0.5 s
    localparam int DEF_REPEAT_RATE     = 5_000_000;   // 0.1 s
    localparam int DEF_CNT_W           = 25;

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: two-flop synchroniser, debounce counter, press/release
// strobes and a hold-to-repeat FSM. All outputs are active-high.
module key_debounce_channel
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_key_n,
    input  logic i_repeat_en,
    output logic o_pressed,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_repeat_pulse
);

    // Terminal counts; counters only ever compare for equality.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_dcnt;
    logic             r_press_pulse;
    logic             r_release_pulse;
    logic             w_accept;
    logic             w_accept_press;
    logic             w_accept_release;

    rep_state_t       r_rep_state;
    rep_state_t       w_rep_state_nxt;
    logic [CNT_W-1:0] r_rcnt;
    logic [CNT_W-1:0] w_rcnt_nxt;
    logic             w_rep_fire;
    logic             r_repeat_pulse;

    // Synchronise the raw key; flops idle at 1 (released, key is active-low).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Inverted second stage: 1 means the key is being pressed.
    assign w_s2 = ~r_sync2;

    // A level change is accepted once it has differed from the stable state
    // for DEBOUNCE_CYCLES consecutive edges.
    assign w_accept         = (w_s2 != r_stable) && (r_dcnt == DB_LAST);
    assign w_accept_press   = w_accept &  w_s2;
    assign w_accept_release = w_accept & ~w_s2;

    // Debounce counter, stable level and the press/release strobes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stable        <= 1'b0;
            r_dcnt          <= '0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_press_pulse   <= w_accept_press;
            r_release_pulse <= w_accept_release;
            if (w_s2 == r_stable) begin
                r_dcnt <= '0;
            end else if (r_dcnt == DB_LAST) begin
                r_stable <= w_s2;
                r_dcnt   <= '0;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
        end
    end

    // Repeat FSM next state; a release or a disable always wins over a due repeat.
    always_comb begin
        w_rep_state_nxt = r_rep_state;
        w_rcnt_nxt      = r_rcnt;
        w_rep_fire      = 1'b0;
        if (w_accept_release || !i_repeat_en) begin
            w_rep_state_nxt = IDLE;
            w_rcnt_nxt      = '0;
        end else begin
            case (r_rep_state)
                IDLE: begin
                    if (w_accept_press) begin
                        w_rep_state_nxt = HOLD_WAIT;
                        w_rcnt_nxt      = '0;
                    end
                end
                HOLD_WAIT: begin
                    if (r_rcnt == RD_LAST) begin
                        w_rep_state_nxt = REPEATING;
                        w_rcnt_nxt      = '0;
                        w_rep_fire      = 1'b1;
                    end else begin
                        w_rcnt_nxt = r_rcnt + 1'b1;
                    end
                end
                REPEATING: begin
                    if (r_rcnt == RR_LAST) begin
                        w_rcnt_nxt = '0;
                        w_rep_fire = 1'b1;
                    end else begin
                        w_rcnt_nxt = r_rcnt + 1'b1;
                    end
                end
                default: begin
                    w_rep_state_nxt = IDLE;
                    w_rcnt_nxt      = '0;
                end
            endcase
        end
    end

    // Repeat FSM state, counter and registered repeat strobe.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rep_state    <= IDLE;
            r_rcnt         <= '0;
            r_repeat_pulse <= 1'b0;
        end else begin
            r_rep_state    <= w_rep_state_nxt;
            r_rcnt         <= w_rcnt_nxt;
            r_repeat_pulse <= w_rep_fire;
        end
    end

    assign o_pressed       = r_stable;
    assign o_press_pulse   = r_press_pulse;
    assign o_release_pulse = r_release_pulse;
    assign o_repeat_pulse  = r_repeat_pulse;

endmodule

// File: rtl/key_conditioner.sv
// Key conditioner: turns raw active-low bouncing push-buttons into debounced
// levels and single-cycle press / release / auto-repeat events per key.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_KEYS        = DEF_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse
);

    // Fully independent channel per key; each drives its own output bit.
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk             (clk),
            .resetn          (resetn),
            .i_key_n         (key_n[gi]),
            .i_repeat_en     (repeat_en[gi]),
            .o_pressed       (pressed[gi]),
            .o_press_pulse   (press_pulse[gi]),
            .o_release_pulse (release_pulse[gi]),
            .o_repeat_pulse  (repeat_pulse[gi])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with a window/schedule reference model.
module tb_key_conditioner;

    localparam int NK = 3;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic [NK-1:0] key_n;
    logic [NK-1:0] repeat_en;
    logic [NK-1:0] pressed;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;
    logic [NK-1:0] repeat_pulse;

    always #5 clk = ~clk;

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR),
        .CNT_W           (CW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .key_n         (key_n),
        .repeat_en     (repeat_en),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {pressed, press_pulse, release_pulse, repeat_pulse} per edge.
    logic [4*NK-1:0] exp_q [$];

    // Reference model: per key, the pressed-level seen at each edge (bit 0
    // newest), the accepted level, and the next scheduled repeat edge.
    logic [DB+1:0] m_hist   [NK];
    logic          m_stable [NK];
    bit            m_rep_on [NK];
    int            m_due    [NK];
    int            m_edge = 0;

    task automatic step(input logic [NK-1:0] kn, input logic [NK-1:0] ren, input logic rn);
        logic [NK-1:0] e_prs, e_pp, e_rp, e_rep;
        logic [DB-1:0] window;
        @(negedge clk);
        key_n     = kn;
        repeat_en = ren;
        resetn    = rn;
        m_edge++;
        e_prs = '0; e_pp = '0; e_rp = '0; e_rep = '0;
        for (int k = 0; k < NK; k++) begin
            if (!rn) begin
                m_hist[k]   = '0;
                m_stable[k] = 1'b0;
                m_rep_on[k] = 1'b0;
            end else begin
                m_hist[k] = {m_hist[k][DB:0], ~kn[k]};
                // Debouncer sees the level two edges late; accept when the last
                // DB observed levels all oppose the accepted level.
                window = m_hist[k][DB+1:2];
                if (window == {DB{~m_stable[k]}}) begin
                    m_stable[k] = ~m_stable[k];
                    if (m_stable[k]) e_pp[k] = 1'b1;
                    else             e_rp[k] = 1'b1;
                end
                if (e_rp[k] || !ren[k]) begin
                    m_rep_on[k] = 1'b0;
                end else if (m_rep_on[k] && m_edge == m_due[k]) begin
                    e_rep[k] = 1'b1;
                    m_due[k] = m_edge + RR;
                end
                if (e_pp[k] && ren[k]) begin
                    m_rep_on[k] = 1'b1;
                    m_due[k]    = m_edge + RD;
                end
            end
            e_prs[k] = m_stable[k];
        end
        exp_q.push_back({e_prs, e_pp, e_rp, e_rep});
    endtask

    task automatic hold(input logic [NK-1:0] kn, input logic [NK-1:0] ren, input int n);
        for (int i = 0; i < n; i++) step(kn, ren, 1'b1);
    endtask

    // Monitor: every edge the DUT presents a full output vector.
    initial begin : monitor
        logic [4*NK-1:0] exp_v, act_v;
        int mon_edge;
        mon_edge = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {pressed, press_pulse, release_pulse, repeat_pulse};
                mon_edge++;
                n_tests++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    if (n_fail <= 20)
                        $display("FAIL outputs edge %0d: got prs/pp/rp/rep=%b required %b",
                                 mon_edge, act_v, exp_v);
                end
            end
        end
    end

    initial begin : driver
        logic [NK-1:0] r_kn, r_ren;
        int            run [NK];
        key_n     = '1;
        repeat_en = '0;
        resetn    = 1'b0;
        for (int k = 0; k < NK; k++) begin
            m_hist[k] = '0; m_stable[k] = 1'b0; m_rep_on[k] = 1'b0; m_due[k] = 0;
        end

        // Reset state.
        step('1, '0, 1'b0);
        step('1, '0, 1'b0);

        // Clean press / release on key 0.
        hold(3'b110, 3'b000, 20);
        hold(3'b111, 3'b000, 12);

        // Bounce rejection on key 1, then a stable press.
        for (int i = 0; i < 5; i++) begin
            hold(3'b101, 3'b000, 3);
            hold(3'b111, 3'b000, 1);
        end
        hold(3'b101, 3'b000, 12);
        hold(3'b111, 3'b000, 12);

        // Auto-repeat on key 2, then release.
        hold(3'b011, 3'b100, 46);
        hold(3'b111, 3'b100, 12);

        // Release accepted on the same edge a repeat is due.
        hold(3'b011, 3'b100, 13);
        hold(3'b111, 3'b100, 12);

        // Disable repeat in HOLD_WAIT: no repeat while held.
        hold(3'b011, 3'b100, 8);
        hold(3'b011, 3'b000, 30);
        hold(3'b111, 3'b000, 10);

        // Reset mid-hold, key still held afterwards.
        hold(3'b110, 3'b000, 10);
        step(3'b110, 3'b000, 1'b0);
        hold(3'b110, 3'b000, 10);
        hold(3'b111, 3'b000, 10);

        // All keys together, staggered releases.
        hold(3'b000, 3'b111, 10);
        hold(3'b001, 3'b111, 3);
        hold(3'b011, 3'b111, 3);
        hold(3'b111, 3'b111, 10);

        // Randomised bouncing keys, repeat enables and occasional reset.
        r_kn  = '1;
        r_ren = '1;
        for (int k = 0; k < NK; k++) run[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (run[k] == 0) begin
                    r_kn[k] = ~r_kn[k];
                    run[k]  = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3)
                                                           : $urandom_range(5, 40);
                end
                run[k]--;
                if ($urandom_range(0, 199) == 0) r_ren[k] = ~r_ren[k];
            end
            step(r_kn, r_ren, ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1);
        end
        hold('1, '1, 12);

        // Every expectation must have been consumed by the monitor.
        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
